// File: rtl/ras_unit.sv
// rtl/ras_unit.sv - return address stack with flush-undo history
module ras_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int HIST  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_addr,
    input  logic                       pop,
    input  logic                       stall,
    input  logic                       flush,
    output logic [XLEN-1:0]            top_addr,
    output logic                       top_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    // History: index 0 is the newest record, HIST-1 the oldest.
    logic [HIST-1:0] h_valid_q, h_valid_d;
    logic [HIST-1:0] h_wr_en_q, h_wr_en_d;
    logic [PW-1:0]   h_ptr_q   [HIST];
    logic [PW-1:0]   h_ptr_d   [HIST];
    logic [CW-1:0]   h_cnt_q   [HIST];
    logic [CW-1:0]   h_cnt_d   [HIST];
    logic [PW-1:0]   h_slot_q  [HIST];
    logic [PW-1:0]   h_slot_d  [HIST];
    logic [XLEN-1:0] h_data_q  [HIST];
    logic [XLEN-1:0] h_data_d  [HIST];

    logic          accept;
    logic          empty;
    logic          full;
    logic          wr_en;
    logic [PW-1:0] wr_slot;

    // Stack op decode, memory write, history shift and flush-undo.
    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        h_valid_d   = h_valid_q;
        h_wr_en_d   = h_wr_en_q;
        h_ptr_d     = h_ptr_q;
        h_cnt_d     = h_cnt_q;
        h_slot_d    = h_slot_q;
        h_data_d    = h_data_q;
        wr_en       = 1'b0;
        wr_slot     = ptr_q;

        accept = !stall && !flush;
        empty  = (count_q == '0);
        full   = (count_q == CW'(DEPTH));

        if (accept) begin
            if (push && pop && !empty) begin
                // Return-and-link: replace TOS in place.
                wr_en   = 1'b1;
                wr_slot = ptr_q;
            end else if (push) begin
                wr_en   = 1'b1;
                wr_slot = ptr_q + 1'b1;
                ptr_d   = ptr_q + 1'b1;
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (pop) begin
                if (empty) begin
                    underflow_d = 1'b1;
                end else begin
                    ptr_d   = ptr_q - 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
        end

        if (wr_en) begin
            mem_d[wr_slot] = push_addr;
        end

        if (flush) begin
            // Walk newest to oldest so the oldest record wins both the
            // pointer/count restore and any slot named twice.
            for (int i = 0; i < HIST; i++) begin
                if (h_valid_q[i]) begin
                    ptr_d   = h_ptr_q[i];
                    count_d = h_cnt_q[i];
                    if (h_wr_en_q[i]) begin
                        mem_d[h_slot_q[i]] = h_data_q[i];
                    end
                end
            end
            h_valid_d = '0;
        end else if (!stall) begin
            for (int i = HIST - 1; i > 0; i--) begin
                h_valid_d[i] = h_valid_q[i-1];
                h_wr_en_d[i] = h_wr_en_q[i-1];
                h_ptr_d[i]   = h_ptr_q[i-1];
                h_cnt_d[i]   = h_cnt_q[i-1];
                h_slot_d[i]  = h_slot_q[i-1];
                h_data_d[i]  = h_data_q[i-1];
            end
            h_valid_d[0] = 1'b1;
            h_wr_en_d[0] = wr_en;
            h_ptr_d[0]   = ptr_q;
            h_cnt_d[0]   = count_q;
            h_slot_d[0]  = wr_slot;
            h_data_d[0]  = mem_q[wr_slot];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            h_valid_q   <= '0;
            h_wr_en_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < HIST; i++) begin
                h_ptr_q[i]  <= '0;
                h_cnt_q[i]  <= '0;
                h_slot_q[i] <= '0;
                h_data_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            h_valid_q   <= h_valid_d;
            h_wr_en_q   <= h_wr_en_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            for (int i = 0; i < HIST; i++) begin
                h_ptr_q[i]  <= h_ptr_d[i];
                h_cnt_q[i]  <= h_cnt_d[i];
                h_slot_q[i] <= h_slot_d[i];
                h_data_q[i] <= h_data_d[i];
            end
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        top_valid = (count_q != '0);
        top_addr  = top_valid ? mem_q[ptr_q] : '0;
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_ras_unit.sv
// tb/tb_ras_unit.sv - scoreboard testbench for ras_unit
module tb_ras_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int HIST  = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            push;
    logic [XLEN-1:0] push_addr;
    logic            pop;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] top_addr;
    logic            top_valid;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;

    ras_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .HIST(HIST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .stall     (stall),
        .flush     (flush),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] top;
        logic            tv;
        logic [CW-1:0]   cnt;
        logic            ov;
        logic            un;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int ov_seen = 0;

    // Reference model: full-state snapshots rather than an undo log.
    logic [XLEN-1:0] m_mem [DEPTH];
    int              m_ptr, m_cnt;
    logic            m_ov, m_un;
    logic [XLEN-1:0] s_mem [HIST][DEPTH];
    int              s_ptr [HIST];
    int              s_cnt [HIST];
    bit              s_v   [HIST];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic ps, input logic [XLEN-1:0] a, input logic pp,
                         input logic st, input logic fl, input logic rs);
        bit done;
        m_ov = 1'b0;
        m_un = 1'b0;
        if (!rs) begin
            m_ptr = 0;
            m_cnt = 0;
            for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
            for (int i = 0; i < HIST; i++) s_v[i] = 1'b0;
        end else if (fl) begin
            done = 1'b0;
            for (int i = HIST - 1; i >= 0; i--) begin
                if (s_v[i] && !done) begin
                    done  = 1'b1;
                    m_ptr = s_ptr[i];
                    m_cnt = s_cnt[i];
                    for (int j = 0; j < DEPTH; j++) m_mem[j] = s_mem[i][j];
                end
            end
            for (int i = 0; i < HIST; i++) s_v[i] = 1'b0;
        end else if (!st) begin
            for (int i = HIST - 1; i > 0; i--) begin
                s_v[i]   = s_v[i-1];
                s_ptr[i] = s_ptr[i-1];
                s_cnt[i] = s_cnt[i-1];
                for (int j = 0; j < DEPTH; j++) s_mem[i][j] = s_mem[i-1][j];
            end
            s_v[0]   = 1'b1;
            s_ptr[0] = m_ptr;
            s_cnt[0] = m_cnt;
            for (int j = 0; j < DEPTH; j++) s_mem[0][j] = m_mem[j];
            if (ps && pp && m_cnt > 0) begin
                m_mem[m_ptr] = a;
            end else if (ps) begin
                m_ptr = (m_ptr + 1) % DEPTH;
                m_mem[m_ptr] = a;
                if (m_cnt == DEPTH) m_ov = 1'b1;
                else m_cnt++;
            end else if (pp) begin
                if (m_cnt == 0) begin
                    m_un = 1'b1;
                end else begin
                    m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                    m_cnt--;
                end
            end
        end
    endtask

    task automatic step(input logic ps, input logic [XLEN-1:0] a, input logic pp,
                        input logic st, input logic fl, input logic rs);
        exp_t e;
        exp_t g;
        @(negedge clk);
        push      = ps;
        push_addr = a;
        pop       = pp;
        stall     = st;
        flush     = fl;
        rst_n     = rs;
        model(ps, a, pp, st, fl, rs);
        e.cnt = CW'(m_cnt);
        e.tv  = (m_cnt > 0);
        e.top = (m_cnt > 0) ? m_mem[m_ptr] : '0;
        e.ov  = m_ov;
        e.un  = m_un;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (overflow === 1'b1) ov_seen++;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            g = exp_q.pop_front();
            chk("sb_top",   64'(top_addr),  64'(g.top));
            chk("sb_valid", 64'(top_valid), 64'(g.tv));
            chk("sb_count", 64'(count),     64'(g.cnt));
            chk("sb_ovf",   64'(overflow),  64'(g.ov));
            chk("sb_unf",   64'(underflow), 64'(g.un));
        end
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic op_push(input logic [XLEN-1:0] a);
        step(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic op_pop();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0; stall = 1'b0; flush = 1'b0;

        do_reset();
        do_reset();
        chk("rst_top",   64'(top_addr),  64'h0);
        chk("rst_valid", 64'(top_valid), 64'h0);
        chk("rst_count", 64'(count),     64'h0);

        // Basic LIFO order.
        op_push(32'h100); op_push(32'h200); op_push(32'h300);
        chk("lifo_top3", 64'(top_addr), 64'h300);
        op_pop();
        chk("lifo_pop1", 64'(top_addr), 64'h200);
        op_pop();
        chk("lifo_pop2", 64'(top_addr), 64'h100);
        chk("lifo_cnt",  64'(count),    64'd1);

        // Overflow by wrap, then drain to underflow.
        do_reset();
        ov_seen = 0;
        for (int k = 1; k <= 9; k++) op_push(32'(k * 16));
        chk("ovf_pulses", 64'(ov_seen), 64'd1);
        chk("ovf_count",  64'(count),   64'd8);
        for (int k = 0; k < 8; k++) begin
            chk("drain_top", 64'(top_addr), 64'(32'h90 - 32'(k * 16)));
            op_pop();
        end
        op_pop();
        chk("unf_pulse", 64'(underflow), 64'd1);
        chk("unf_count", 64'(count),     64'd0);
        chk("unf_top",   64'(top_addr),  64'd0);

        // Same-cycle push and pop.
        do_reset();
        op_push(32'h40);
        step(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp_top", 64'(top_addr), 64'h80);
        chk("pp_cnt", 64'(count),    64'd1);
        do_reset();
        step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp_empty_cnt", 64'(count),     64'd1);
        chk("pp_empty_unf", 64'(underflow), 64'd0);

        // Flush undoes the two most recent accepted pushes.
        do_reset();
        op_push(32'hA); op_push(32'hB); op_push(32'hC);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fl_cnt",   64'(count),        64'd1);
        chk("fl_top",   64'(top_addr),     64'hA);
        chk("fl_slot2", 64'(dut.mem_q[2]), 64'h0);
        chk("fl_slot3", 64'(dut.mem_q[3]), 64'h0);

        // Stall freezes state and history; flush overrides stall.
        do_reset();
        op_push(32'h1); op_push(32'h2);
        for (int k = 0; k < 3; k++) step(1'b1, 32'h3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("stall_cnt", 64'(count),    64'd2);
        chk("stall_top", 64'(top_addr), 64'h2);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("stfl_cnt",  64'(count),    64'd0);

        // Reset beats push and flush; later flush is a no-op.
        do_reset();
        op_push(32'h5); op_push(32'h6);
        step(1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstov_cnt", 64'(count),    64'd0);
        chk("rstov_top", 64'(top_addr), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rstfl_cnt", 64'(count),    64'd0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 1) == 1), $urandom(), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
